// File: rtl/uart_prog_loader.sv
// UART program loader: 8N1 receiver feeding a framed word-write protocol (A5, len16, data words).
// Defining LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (state CHK).
module uart_prog_loader #(
    parameter int CLK_DIV      = 217,
    parameter int TIMEOUT_BITS = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic [15:0] PROGADD,
    output logic [15:0] PROGDATA,
    output logic        PROGWE,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);
    localparam logic [31:0] TO_M1   = 32'(TIMEOUT_BITS * CLK_DIV - 1);
    localparam logic [7:0]  SYNC    = 8'hA5;

    // ---------------- receiver ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t   rx_state, rx_next;
    logic        rx_m, rx_s, rx_q;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_byte;
    logic        byte_done, frame_err;

    always_comb begin
        rx_next   = rx_state;
        byte_done = 1'b0;
        frame_err = 1'b0;
        unique case (rx_state)
            RX_IDLE:  if (rx_q && !rx_s) rx_next = RX_START;
            RX_START: if (rx_cnt == HALF_M1) rx_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_cnt == DIV_M1 && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP: begin
                if (rx_cnt == DIV_M1) begin
                    rx_next   = RX_IDLE;
                    byte_done = rx_s;
                    frame_err = !rx_s;
                end
            end
            default:  rx_next = RX_IDLE;
        endcase
    end

    // Sync flops reset low so a line held low across reset cannot look like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m     <= 1'b0;
            rx_s     <= 1'b0;
            rx_q     <= 1'b0;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_byte  <= '0;
        end else begin
            rx_m     <= uart_rx;
            rx_s     <= rx_m;
            rx_q     <= rx_s;
            rx_state <= rx_next;
            if (rx_next != rx_state || rx_state == RX_IDLE || rx_cnt == DIV_M1)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + 16'd1;
            if (rx_state == RX_DATA && rx_cnt == DIV_M1) begin
                rx_byte <= {rx_s, rx_byte[7:1]};
                rx_bit  <= rx_bit + 3'd1;
            end
        end
    end

    // ---------------- protocol ----------------
`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {P_IDLE, P_LEN_LO, P_LEN_HI, P_DAT_LO, P_DAT_HI, P_CHK, P_DONE} p_state_t;
    localparam p_state_t P_END = P_CHK;
    logic [7:0] xor_acc;
`else
    typedef enum logic [2:0] {P_IDLE, P_LEN_LO, P_LEN_HI, P_DAT_LO, P_DAT_HI, P_DONE} p_state_t;
    localparam p_state_t P_END = P_DONE;
`endif

    p_state_t    p_state, p_next;
    logic [7:0]  len_lo, dat_lo;
    logic [15:0] words_left;
    logic [31:0] to_cnt;
    logic        active, timeout;

    assign active  = (p_state != P_IDLE) && (p_state != P_DONE);
    // A byte finishing on the expiry cycle wins over the timeout.
    assign timeout = active && (to_cnt == TO_M1) && !byte_done;

    always_comb begin
        p_next = p_state;
        if (frame_err || timeout) begin
            p_next = P_IDLE;
        end else if (byte_done) begin
            unique case (p_state)
                P_IDLE, P_DONE: if (rx_byte == SYNC) p_next = P_LEN_LO;
                P_LEN_LO: p_next = P_LEN_HI;
                P_LEN_HI: p_next = ({rx_byte, len_lo} == 16'd0) ? P_END : P_DAT_LO;
                P_DAT_LO: p_next = P_DAT_HI;
                P_DAT_HI: p_next = (words_left == 16'd1) ? P_END : P_DAT_LO;
`ifdef LOADER_CHECKSUM_EN
                P_CHK:    p_next = P_DONE;
`endif
                default:  p_next = P_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_state    <= P_IDLE;
            PROGADD    <= '0;
            PROGDATA   <= '0;
            PROGWE     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            len_lo     <= '0;
            dat_lo     <= '0;
            words_left <= '0;
            to_cnt     <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_acc    <= '0;
`endif
        end else begin
            p_state <= p_next;
            PROGWE  <= 1'b0;
            if (!active || byte_done || timeout)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 32'd1;
            if (PROGWE)
                PROGADD <= PROGADD + 16'd1;

            if (frame_err || timeout) begin
                err  <= 1'b1;
                busy <= 1'b0;
            end else if (byte_done) begin
                unique case (p_state)
                    P_IDLE, P_DONE: begin
                        if (rx_byte == SYNC) begin
                            done    <= 1'b0;
                            err     <= 1'b0;
                            busy    <= 1'b1;
                            PROGADD <= '0;
`ifdef LOADER_CHECKSUM_EN
                            xor_acc <= '0;
`endif
                        end
                    end
                    P_LEN_LO: len_lo <= rx_byte;
                    P_LEN_HI: begin
                        words_left <= {rx_byte, len_lo};
`ifndef LOADER_CHECKSUM_EN
                        if ({rx_byte, len_lo} == 16'd0) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                        end
`endif
                    end
                    P_DAT_LO: begin
                        dat_lo <= rx_byte;
`ifdef LOADER_CHECKSUM_EN
                        xor_acc <= xor_acc ^ rx_byte;
`endif
                    end
                    P_DAT_HI: begin
                        PROGDATA   <= {rx_byte, dat_lo};
                        PROGWE     <= 1'b1;
                        words_left <= words_left - 16'd1;
`ifdef LOADER_CHECKSUM_EN
                        xor_acc <= xor_acc ^ rx_byte;
`else
                        if (words_left == 16'd1) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                        end
`endif
                    end
`ifdef LOADER_CHECKSUM_EN
                    P_CHK: begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        if (rx_byte != xor_acc) err <= 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: byte-level protocol model plus per-cycle write checker.
module tb_uart_prog_loader;

    localparam int DIV = 16;
    localparam int TOB = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx = 1'b1;
    logic [15:0] PROGADD, PROGDATA;
    logic        PROGWE, busy, done, err;

    uart_prog_loader #(.CLK_DIV(DIV), .TIMEOUT_BITS(TOB)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx),
        .PROGADD(PROGADD), .PROGDATA(PROGDATA), .PROGWE(PROGWE),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Protocol model: 0 idle, 1 len_lo, 2 len_hi, 3 dat_lo, 4 dat_hi, 5 chk, 6 done
    int          m_st;
    logic [15:0] m_addr, m_left;
    logic [7:0]  m_lo, m_xor;
    logic        m_done, m_err, m_busy;
    logic [15:0] exp_addr[$], exp_data[$];
    logic [15:0] obs_addr[$], obs_data[$];

    task automatic model_reset();
        m_st = 0; m_addr = 0; m_left = 0; m_lo = 0; m_xor = 0;
        m_done = 0; m_err = 0; m_busy = 0;
    endtask

    task automatic model_end();
`ifdef LOADER_CHECKSUM_EN
        m_st = 5;
`else
        m_st = 6; m_done = 1; m_busy = 0;
`endif
    endtask

    task automatic model_byte(input logic [7:0] b);
        case (m_st)
            0, 6: if (b == 8'hA5) begin
                m_st = 1; m_done = 0; m_err = 0; m_busy = 1; m_addr = 0; m_xor = 0;
            end
            1: begin m_lo = b; m_st = 2; end
            2: begin
                m_left = {b, m_lo};
                if (m_left == 0) model_end(); else m_st = 3;
            end
            3: begin m_lo = b; m_xor ^= b; m_st = 4; end
            4: begin
                m_xor ^= b;
                exp_addr.push_back(m_addr);
                exp_data.push_back({b, m_lo});
                m_addr++;
                m_left--;
                if (m_left == 0) model_end(); else m_st = 3;
            end
            5: begin m_err = (b != m_xor); m_st = 6; m_done = 1; m_busy = 0; end
            default: m_st = 0;
        endcase
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop = 1'b1);
        if (stop) model_byte(b);
        else begin m_err = 1; m_busy = 0; m_st = 0; end
        uart_rx = 1'b0; tick(DIV);
        for (int i = 0; i < 8; i++) begin uart_rx = b[i]; tick(DIV); end
        uart_rx = stop; tick(DIV);
        uart_rx = 1'b1; tick(2 * DIV);
    endtask

    task automatic send_ck(input logic [7:0] c);
`ifdef LOADER_CHECKSUM_EN
        send(c);
`else
        if (c == 8'h00) tick(1);
`endif
    endtask

    task automatic chk_status(input string tag);
        @(negedge clk);
        chk({tag, "_done"}, {31'd0, done}, {31'd0, m_done});
        chk({tag, "_err"},  {31'd0, err},  {31'd0, m_err});
        chk({tag, "_busy"}, {31'd0, busy}, {31'd0, m_busy});
        chk({tag, "_pending"}, exp_addr.size(), 0);
        tick(1);
    endtask

    // Every write strobe must match the next expected write.
    always @(negedge clk) begin
        if (!rst && PROGWE) begin
            obs_addr.push_back(PROGADD);
            obs_data.push_back(PROGDATA);
            if (exp_addr.size() == 0) begin
                chk("unexpected_we", {16'd0, PROGADD}, 32'hFFFF_FFFF);
            end else begin
                chk("we_addr", {16'd0, PROGADD},  {16'd0, exp_addr.pop_front()});
                chk("we_data", {16'd0, PROGDATA}, {16'd0, exp_data.pop_front()});
            end
        end
    end

    initial begin
        model_reset();
        tick(5);
        @(negedge clk);
        chk("rst_addr", {16'd0, PROGADD}, 0);
        chk("rst_data", {16'd0, PROGDATA}, 0);
        chk("rst_we",   {31'd0, PROGWE}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err",  {31'd0, err}, 0);
        tick(1);
        rst = 1'b0;
        tick(4 * DIV);

        // short low glitch is not a start bit
        uart_rx = 1'b0; tick(3); uart_rx = 1'b1; tick(3 * DIV);
        chk_status("glitch");

        // two-word session
        send(8'hA5); send(8'h02); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send_ck(8'h44);
        chk_status("two_words");
        chk("lit_n_writes", obs_addr.size(), 2);
        chk("lit_w0_addr", {16'd0, obs_addr[0]}, 32'h0000);
        chk("lit_w0_data", {16'd0, obs_data[0]}, 32'h2211);
        chk("lit_w1_addr", {16'd0, obs_addr[1]}, 32'h0001);
        chk("lit_w1_data", {16'd0, obs_data[1]}, 32'h4433);
        chk("lit_done", {31'd0, done}, 1);

        // leading junk ignored, new session restarts address at 0
        send(8'h00); send(8'hA5); send(8'h01); send(8'h00);
        send(8'hEF); send(8'hBE); send_ck(8'h51);
        chk_status("beef");
        chk("lit_beef_addr", {16'd0, obs_addr[2]}, 32'h0000);
        chk("lit_beef_data", {16'd0, obs_data[2]}, 32'hBEEF);

        // zero-length session
        send(8'hA5); send(8'h00); send(8'h00); send_ck(8'h00);
        chk_status("zero_len");

        // framing error, then A5 clears err
        send(8'hA5); send(8'h01, 1'b0);
        chk_status("frame_err");
        chk("lit_frame_err", {31'd0, err}, 1);
        send(8'hA5);
        chk_status("resync");
        send(8'h01); send(8'h00); send(8'h34); send(8'h12); send_ck(8'h26);
        chk_status("after_resync");

        // timeout mid-session; subsequent bytes without A5 do nothing
        send(8'hA5); send(8'h01);
        tick(TOB * DIV + 50);
        m_err = 1; m_busy = 0; m_st = 0;
        chk_status("timeout");
        send(8'h01); send(8'h00); send(8'hEF); send(8'hBE);
        chk_status("timeout_idle");

`ifdef LOADER_CHECKSUM_EN
        send(8'hA5); send(8'h01); send(8'h00); send(8'h0F); send(8'hF0); send(8'h00);
        chk_status("bad_cksum");
        chk("lit_cksum_err", {31'd0, err}, 1);
        chk("lit_cksum_done", {31'd0, done}, 1);
`endif

        // reset during DAT_HI reception of the second word
        send(8'hA5); send(8'h02); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33);
        uart_rx = 1'b0; tick(DIV);
        for (int i = 0; i < 4; i++) begin uart_rx = 1'b0; tick(DIV); end
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_addr", {16'd0, PROGADD}, 0);
        chk("mid_rst_data", {16'd0, PROGDATA}, 0);
        chk("mid_rst_we",   {31'd0, PROGWE}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_done", {31'd0, done}, 0);
        chk("mid_rst_err",  {31'd0, err}, 0);
        tick(1);
        model_reset();
        rst = 1'b0;
        uart_rx = 1'b1;
        tick(TOB * DIV / 2);
        chk_status("post_rst");

        send(8'hA5); send(8'h01); send(8'h00); send(8'hCD); send(8'hAB); send_ck(8'h66);
        chk_status("recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
